// File: rtl/rv32_lsu_pkg.sv
// Shared types and helpers for the load/store unit and its store buffer.
package rv32_lsu_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           be;
  } sb_entry_t;

  // Word-aligned base of a byte address; two addresses in the same word
  // compare equal after this.
  function automatic logic [SB_ADDR_W-1:0] word_base(input logic [SB_ADDR_W-1:0] a);
    return a & ~SB_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/rv32_sb_youngest_match.sv
// Picks the youngest matching entry: the first match found walking
// backwards from the slot just behind the write pointer.
module rv32_sb_youngest_match #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  output logic             hit_o,
  output logic [DEPTH-1:0] youngest_oh_o
);

  logic [PTR_W-1:0] idx;

  // Priority scan from newest to oldest; pointer arithmetic wraps mod DEPTH.
  always_comb begin
    hit_o         = 1'b0;
    youngest_oh_o = '0;
    idx           = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_ptr_i - PTR_W'(k + 1);
      if (!hit_o && match_i[idx]) begin
        hit_o              = 1'b1;
        youngest_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_store_buffer.sv
// Posted-store FIFO: accepts committed stores, retires them in order to
// data memory over req/gnt, and forwards pending data to younger loads.
module rv32_store_buffer
  import rv32_lsu_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_be,
  output logic                     mem_req,
  input  logic                     mem_gnt,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_hit_data,
  output logic [3:0]               ld_hit_be,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop;
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] youngest_oh;
  sb_entry_t        head;

  assign sb_count  = count_q;
  assign sb_empty  = (count_q == '0);
  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign mem_req   = !sb_empty;
  assign push      = st_valid && st_ready;
  assign pop       = mem_req && mem_gnt;

  assign head      = entry_q[rd_ptr_q];
  assign mem_addr  = head.addr[ADDR_W-1:0];
  assign mem_wdata = head.data;
  assign mem_be    = head.be;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage, valid bits and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= '{addr: SB_ADDR_W'(st_addr), data: st_data, be: st_be};
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Word-address compare against every valid entry.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] &&
                 (word_base(entry_q[i].addr) == word_base(SB_ADDR_W'(ld_addr)));
    end
  end

  rv32_sb_youngest_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_youngest (
    .match_i       (match),
    .wr_ptr_i      (wr_ptr_q),
    .hit_o         (ld_hit),
    .youngest_oh_o (youngest_oh)
  );

  // One-hot mux of the youngest match; all zero when nothing matched.
  always_comb begin
    ld_hit_data = '0;
    ld_hit_be   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (youngest_oh[i]) begin
        ld_hit_data = ld_hit_data | entry_q[i].data;
        ld_hit_be   = ld_hit_be   | entry_q[i].be;
      end
    end
  end

endmodule

// File: tb/tb_rv32_store_buffer.sv
// Bench for rv32_store_buffer: directed scenarios plus random traffic,
// compared against a queue-based model of the pending stores.
module tb_rv32_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              st_valid, st_ready;
  logic [31:0]       st_addr, st_data;
  logic [3:0]        st_be;
  logic              mem_req, mem_gnt;
  logic [31:0]       mem_addr, mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       ld_addr;
  logic              ld_hit;
  logic [31:0]       ld_hit_data;
  logic [3:0]        ld_hit_be;
  logic              sb_empty;
  logic [2:0]        sb_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t mq[$];

  rv32_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_be       (st_be),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_hit_data (ld_hit_data),
    .ld_hit_be   (ld_hit_be),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  always #5 clk = ~clk;

  // Youngest pending store in the same 32-bit word as la.
  function automatic void ref_lookup(input logic [31:0] la, output logic h,
                                     output logic [31:0] d, output logic [3:0] b);
    h = 1'b0; d = '0; b = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr[31:2] == la[31:2]) begin
        h = 1'b1; d = mq[i].data; b = mq[i].be;
        return;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic g, input logic [31:0] la);
    st_valid = v; st_addr = a; st_data = d; st_be = b; mem_gnt = g; ld_addr = la;
  endtask

  // Clock edge plus model update from the inputs presented this cycle.
  task automatic cyc();
    bit  acc, pp;
    st_t e;
    @(posedge clk);
    acc = st_valid && (mq.size() < DEPTH);
    pp  = mem_gnt && (mq.size() != 0);
    e.addr = st_addr; e.data = st_data; e.be = st_be;
    if (pp)  void'(mq.pop_front());
    if (acc) mq.push_back(e);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, a, d, b, 1'b0, 32'h0);
    cyc();
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    mq.delete();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    mq.delete();
    #3;
    total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", sb_count); end
    total++; if ({sb_empty, st_ready, mem_req, ld_hit} !== 4'b1100) begin bad++; $display("FAIL reset_flags got=%b exp=1100", {sb_empty, st_ready, mem_req, ld_hit}); end
    total++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin bad++; $display("FAIL reset_head got=%h exp=0", {mem_addr, mem_wdata, mem_be}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    logic [31:0] d;
    do_reset();
    push(32'h100, 32'h11, 4'hF);
    push(32'h104, 32'h22, 4'hF);
    push(32'h108, 32'h33, 4'hF);
    push(32'h10C, 32'h44, 4'hF);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0); #1;
    total++; if (sb_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", sb_count); end
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", st_ready); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fill_head got=%h exp=100", mem_addr); end
    cyc(); cyc(); #1;
    total++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'h11}) begin bad++; $display("FAIL hold_head got=%h exp=%h", {mem_req, mem_addr, mem_wdata}, {1'b1, 32'h100, 32'h11}); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0); #1;
      d = 32'h11 * (i + 1);
      total++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100 + 32'(4 * i), d}) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, {mem_req, mem_addr, mem_wdata}, {1'b1, 32'h100 + 32'(4 * i), d}); end
      cyc();
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0); #1;
    total++; if ({sb_empty, mem_req, sb_count} !== {2'b10, 3'd0}) begin bad++; $display("FAIL drain_empty got=%b exp=10000", {sb_empty, mem_req, sb_count}); end
  endtask

  task automatic test_youngest();
    do_reset();
    push(32'h200, 32'hAAAA_AAAA, 4'hF);
    push(32'h200, 32'h0000_00BB, 4'h1);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h203); #1;
    total++; if ({ld_hit, ld_hit_data, ld_hit_be} !== {1'b1, 32'h0000_00BB, 4'h1}) begin bad++; $display("FAIL youngest got=%h exp=%h", {ld_hit, ld_hit_data, ld_hit_be}, {1'b1, 32'h0000_00BB, 4'h1}); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h204); #1;
    total++; if ({ld_hit, ld_hit_data, ld_hit_be} !== 37'h0) begin bad++; $display("FAIL miss got=%h exp=0", {ld_hit, ld_hit_data, ld_hit_be}); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 32'(i), 4'hF);
    drive(1'b1, 32'h380, 32'h55, 4'h3, 1'b1, 32'h0); #1;
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", st_ready); end
    cyc(); #1;
    total++; if (sb_count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", sb_count); end
    drive(1'b1, 32'h380, 32'h55, 4'h3, 1'b0, 32'h380); #1;
    total++; if ({st_ready, ld_hit} !== 2'b10) begin bad++; $display("FAIL full_retry got=%b exp=10", {st_ready, ld_hit}); end
    cyc();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h380); #1;
    total++; if ({sb_count, ld_hit, ld_hit_data, ld_hit_be} !== {3'd4, 1'b1, 32'h55, 4'h3}) begin bad++; $display("FAIL full_tail got=%h exp=%h", {sb_count, ld_hit, ld_hit_data, ld_hit_be}, {3'd4, 1'b1, 32'h55, 4'h3}); end
  endtask

  task automatic test_push_pop_count2();
    do_reset();
    push(32'h400, 32'h1, 4'hF);
    push(32'h404, 32'h2, 4'hF);
    drive(1'b1, 32'h408, 32'h3, 4'hF, 1'b1, 32'h400); #1;
    total++; if ({ld_hit, ld_hit_data} !== {1'b1, 32'h1}) begin bad++; $display("FAIL popping_lookup got=%h exp=%h", {ld_hit, ld_hit_data}, {1'b1, 32'h1}); end
    cyc();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h400); #1;
    total++; if ({sb_count, ld_hit, mem_addr} !== {3'd2, 1'b0, 32'h404}) begin bad++; $display("FAIL pp2_state got=%h exp=%h", {sb_count, ld_hit, mem_addr}, {3'd2, 1'b0, 32'h404}); end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h408); #1;
    total++; if ({ld_hit, ld_hit_data} !== {1'b1, 32'h3}) begin bad++; $display("FAIL pp2_tail got=%h exp=%h", {ld_hit, ld_hit_data}, {1'b1, 32'h3}); end
  endtask

  // Random traffic; iters and occupancy shape come from the caller.
  task automatic test_random(input string tag, input int iters, input bit pairs);
    logic        h, v, g;
    logic [31:0] d, a, la;
    logic [3:0]  b;
    for (int n = 0; n < iters; n++) begin
      a  = 32'h500 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      la = 32'h500 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      v  = pairs ? 1'b1 : 1'($urandom_range(0, 1));
      g  = pairs ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      drive(v, a, $urandom, 4'($urandom), g, la); #1;
      ref_lookup(la, h, d, b);
      total++; if ({ld_hit, ld_hit_data, ld_hit_be} !== {h, d, b}) begin bad++; $display("FAIL %s_lookup n=%0d got=%h exp=%h", tag, n, {ld_hit, ld_hit_data, ld_hit_be}, {h, d, b}); end
      total++; if ({sb_count, mem_req, st_ready} !== {3'(mq.size()), mq.size() != 0, mq.size() < DEPTH}) begin bad++; $display("FAIL %s_occ n=%0d got=%b exp=%b", tag, n, {sb_count, mem_req, st_ready}, {3'(mq.size()), mq.size() != 0, mq.size() < DEPTH}); end
      if (mq.size() != 0) begin
        total++; if ({mem_addr, mem_wdata, mem_be} !== {mq[0].addr, mq[0].data, mq[0].be}) begin bad++; $display("FAIL %s_head n=%0d got=%h exp=%h", tag, n, {mem_addr, mem_wdata, mem_be}, {mq[0].addr, mq[0].data, mq[0].be}); end
      end
      cyc();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    push(32'h500, 32'hA0, 4'hF);
    push(32'h504, 32'hA1, 4'h3);
    push(32'h500, 32'hA2, 4'hC);
    test_random("wrap", 10, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(32'h600, 32'h61, 4'hF);
    push(32'h604, 32'h62, 4'hF);
    push(32'h608, 32'h63, 4'hF);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h604); #1;
    total++; if ({mem_req, ld_hit, sb_count} !== {2'b11, 3'd3}) begin bad++; $display("FAIL pre_rst got=%b exp=11011", {mem_req, ld_hit, sb_count}); end
    #1 rst_n = 1'b0;
    mq.delete();
    #1;
    total++; if ({mem_req, ld_hit, sb_count, st_ready} !== {2'b00, 3'd0, 1'b1}) begin bad++; $display("FAIL async_rst got=%b exp=000001", {mem_req, ld_hit, sb_count, st_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h604);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({mem_req, sb_empty, ld_hit} !== 3'b010) begin bad++; $display("FAIL post_rst_%0d got=%b exp=010", i, {mem_req, sb_empty, ld_hit}); end
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_youngest();
    test_full_push_pop();
    test_push_pop_count2();
    test_wrap();
    do_reset();
    test_random("rnd", 300, 1'b0);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
